// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e      : frame FSM states
//   SAMPLES_PER_BIT : baud_tick enables per serial bit (16x oversampling)
//   ST_*            : bit positions inside status_register
//   frame_parity    : parity bit for a data word (zero-extended to 8 bits)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned SAMPLES_PER_BIT = 16;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_OVF   = 2;
    localparam int unsigned ST_DONE  = 3;

    // Zero padding of narrow words leaves the reduction unchanged.
    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Bus-side interface of the UART transmitter.
//   write_data      : push strobe, one word per high cycle
//   bus_data_in     : word to transmit
//   clr_status      : clears the sticky status bits
//   status_register : {4'b0, tx_done, overflow_error, empty, full}
// master = bus agent, slave = transmitter.
interface uart_transmitter_if #(
    parameter int unsigned DATA_SIZE = 8
);

    logic                 write_data;
    logic [DATA_SIZE-1:0] bus_data_in;
    logic                 clr_status;
    logic [7:0]           status_register;

    modport master (
        output write_data,
        output bus_data_in,
        output clr_status,
        input  status_register
    );

    modport slave (
        input  write_data,
        input  bus_data_in,
        input  clr_status,
        output status_register
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock FIFO for the transmit path.
//   clk, reset_n : clock, asynchronous active-low reset
//   write        : push data_in (ignored when full)
//   read         : pop head (ignored when empty)
//   data_in      : word to push
//   data_out     : registered head of queue, valid whenever ~empty
//   full, empty  : occupancy flags derived from the pointers
// Pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_next;
    logic             do_write;
    logic             do_read;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_write    = write && !full;
    assign do_read     = read && !empty;
    assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, do_read};

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr <= rd_ptr_next;
            // The next head is the slot being written right now when the queue
            // is (or is about to become) empty, so bypass the array for it.
            if (do_write && (rd_ptr_next == wr_ptr)) begin
                data_out <= data_in;
            end else begin
                data_out <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: TX FIFO plus frame serialiser.
//   clk, reset_n    : clock, asynchronous active-low reset
//   baud_tick       : one-clk enable at 16x the baud rate
//   parity_en       : append a parity bit (latched per frame)
//   parity_odd      : 1 = odd parity, 0 = even (latched per frame)
//   two_stop        : 1 = two stop bits (latched per frame)
//   serial_data_out : registered TX line, idles high
//   tx_busy         : high while the FSM is not in IDLE
//   bus             : push strobe, data word, status clear and status_register
// Frame: start, DATA_SIZE data bits LSB first, optional parity, 1 or 2 stops;
// every bit lasts SAMPLES_PER_BIT baud ticks.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = 8,
    parameter int unsigned SIZE_FIFO      = 8,
    parameter int unsigned BIT_COUNT_SIZE = $clog2(DATA_SIZE)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              baud_tick,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop,
    output logic              serial_data_out,
    output logic              tx_busy,
    uart_transmitter_if.slave bus
);

    logic [DATA_SIZE-1:0]      fifo_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_read;

    tx_state_e                 state;
    logic [3:0]                sample_count;
    logic                      stop_ext;
    logic [BIT_COUNT_SIZE-1:0] bit_count;
    logic [DATA_SIZE-1:0]      tx_shift_reg;
    logic                      parity_bit;
    logic                      cfg_parity_en;
    logic                      cfg_two_stop;

    logic                      last_sample;
    logic                      last_data_bit;
    logic                      tx_done;
    logic                      overflow_error;
    logic                      done_flag;

    uart_tx_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (SIZE_FIFO)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .write    (bus.write_data),
        .read     (fifo_read),
        .data_in  (bus.bus_data_in),
        .data_out (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign last_sample   = (sample_count == 4'(SAMPLES_PER_BIT - 1));
    assign last_data_bit = (bit_count == BIT_COUNT_SIZE'(DATA_SIZE - 1));

    // Final tick of the final stop bit; stop_ext marks the second stop bit.
    assign tx_done = baud_tick && (state == STOP) && last_sample && (stop_ext || !cfg_two_stop);

    // Pop from IDLE, or straight out of the last stop tick for back-to-back frames.
    assign fifo_read = baud_tick && !fifo_empty && ((state == IDLE) || tx_done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            sample_count    <= '0;
            stop_ext        <= 1'b0;
            bit_count       <= '0;
            tx_shift_reg    <= '0;
            parity_bit      <= 1'b0;
            cfg_parity_en   <= 1'b0;
            cfg_two_stop    <= 1'b0;
            serial_data_out <= 1'b1;
            tx_busy         <= 1'b0;
        end else if (baud_tick) begin
            if (state != IDLE) begin
                sample_count <= sample_count + 4'd1;
            end
            case (state)
                IDLE: begin
                    // Frame load is handled by the fifo_read block below.
                end
                START: begin
                    if (last_sample) begin
                        state           <= DATA;
                        bit_count       <= '0;
                        serial_data_out <= tx_shift_reg[0];
                    end
                end
                DATA: begin
                    if (last_sample) begin
                        tx_shift_reg <= tx_shift_reg >> 1;
                        bit_count    <= bit_count + BIT_COUNT_SIZE'(1);
                        if (last_data_bit) begin
                            if (cfg_parity_en) begin
                                state           <= PARITY;
                                serial_data_out <= parity_bit;
                            end else begin
                                state           <= STOP;
                                stop_ext        <= 1'b0;
                                serial_data_out <= 1'b1;
                            end
                        end else begin
                            serial_data_out <= tx_shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (last_sample) begin
                        state           <= STOP;
                        stop_ext        <= 1'b0;
                        serial_data_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (last_sample) begin
                        if (tx_done) begin
                            state           <= IDLE;
                            tx_busy         <= 1'b0;
                            serial_data_out <= 1'b1;
                        end else begin
                            stop_ext <= 1'b1;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    tx_busy         <= 1'b0;
                    serial_data_out <= 1'b1;
                end
            endcase
            // Starting a frame overrides whatever the case above scheduled.
            if (fifo_read) begin
                state           <= START;
                tx_busy         <= 1'b1;
                sample_count    <= '0;
                tx_shift_reg    <= fifo_data;
                parity_bit      <= frame_parity(8'(fifo_data), parity_odd);
                cfg_parity_en   <= parity_en;
                cfg_two_stop    <= two_stop;
                serial_data_out <= 1'b0;
            end
        end
    end

    // Sticky status; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_error <= 1'b0;
            done_flag      <= 1'b0;
        end else begin
            if (bus.write_data && fifo_full) begin
                overflow_error <= 1'b1;
            end else if (bus.clr_status) begin
                overflow_error <= 1'b0;
            end
            if (tx_done) begin
                done_flag <= 1'b1;
            end else if (bus.clr_status) begin
                done_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.status_register           = '0;
        bus.status_register[ST_FULL]  = fifo_full;
        bus.status_register[ST_EMPTY] = fifo_empty;
        bus.status_register[ST_OVF]   = overflow_error;
        bus.status_register[ST_DONE]  = done_flag;
    end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int unsigned DATA_SIZE = 8;
    localparam int unsigned SIZE_FIFO = 8;

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic baud_tick  = 1'b0;
    logic parity_en  = 1'b0;
    logic parity_odd = 1'b0;
    logic two_stop   = 1'b0;
    logic serial_data_out;
    logic tx_busy;

    uart_transmitter_if #(.DATA_SIZE(DATA_SIZE)) bus ();

    uart_transmitter #(
        .DATA_SIZE (DATA_SIZE),
        .SIZE_FIFO (SIZE_FIFO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .baud_tick       (baud_tick),
        .parity_en       (parity_en),
        .parity_odd      (parity_odd),
        .two_stop        (two_stop),
        .serial_data_out (serial_data_out),
        .tx_busy         (tx_busy),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Baud enable: one clk high out of every four while tick_en is set.
    bit tick_en = 1'b0;
    int div     = 0;
    always @(negedge clk) begin
        if (tick_en) begin
            div       = (div == 3) ? 0 : div + 1;
            baud_tick = (div == 3);
        end else begin
            div       = 0;
            baud_tick = 1'b0;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_odd;
        bit         two_stop;
        int         wr_tick;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   tick_num    = 0;
    int   frames_done = 0;

    // Monitor state
    bit          mon_active  = 1'b0;
    bit          end_pending = 1'b0;
    bit          bad;
    logic        bad_line;
    logic        bad_busy;
    logic [15:0] fbits;
    int          nbits;
    int          bit_idx     = 0;
    int          sub         = 0;
    exp_t        cur;

    // Samples the line 1 time unit after every baud-tick edge and checks each
    // serial bit against the frame built from the scoreboard entry.
    initial begin
        forever begin
            @(posedge clk);
            if (baud_tick) begin
                #1;
                if (!reset_n) begin
                    mon_active  = 1'b0;
                    end_pending = 1'b0;
                end else begin
                    tick_num++;
                    if (end_pending) begin
                        end_pending = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            if (tx_busy !== 1'b0 || serial_data_out !== 1'b1 ||
                                bus.status_register[ST_DONE] !== 1'b1) begin
                                n_fail++;
                                $display("FAIL frame_end: busy=%b line=%b done=%b, required 0 1 1",
                                         tx_busy, serial_data_out,
                                         bus.status_register[ST_DONE]);
                            end
                        end else if (exp_q[0].wr_tick + 2 < tick_num) begin
                            n_checks++;
                            if (serial_data_out !== 1'b0 || tx_busy !== 1'b1) begin
                                n_fail++;
                                $display("FAIL back_to_back: line=%b busy=%b, required 0 1",
                                         serial_data_out, tx_busy);
                            end
                        end
                    end
                    if (!mon_active && serial_data_out === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_frame: start bit at tick %0d, none queued",
                                     tick_num);
                        end else begin
                            int ones;
                            logic pbit;
                            cur   = exp_q.pop_front();
                            fbits = '1;
                            fbits[0] = 1'b0;
                            ones = 0;
                            for (int i = 0; i < 8; i++) begin
                                fbits[i+1] = cur.data[i];
                                ones += int'(cur.data[i]);
                            end
                            nbits = 9;
                            if (cur.par_en) begin
                                pbit = (ones % 2 == 1);
                                if (cur.par_odd) pbit = ~pbit;
                                fbits[nbits] = pbit;
                                nbits++;
                            end
                            nbits += cur.two_stop ? 2 : 1;
                            start_q.push_back(tick_num);
                            mon_active = 1'b1;
                            bit_idx    = 0;
                            sub        = 0;
                            bad        = 1'b0;
                        end
                    end
                    if (mon_active) begin
                        if (!bad && (serial_data_out !== fbits[bit_idx] || tx_busy !== 1'b1)) begin
                            bad      = 1'b1;
                            bad_line = serial_data_out;
                            bad_busy = tx_busy;
                        end
                        sub++;
                        if (sub == 16) begin
                            n_checks++;
                            if (bad) begin
                                n_fail++;
                                $display("FAIL frame_bit: word 0x%02h bit %0d line=%b busy=%b, required line=%b busy=1",
                                         cur.data, bit_idx, bad_line, bad_busy, fbits[bit_idx]);
                            end
                            sub = 0;
                            bad = 1'b0;
                            bit_idx++;
                            if (bit_idx == nbits) begin
                                mon_active  = 1'b0;
                                end_pending = 1'b1;
                                frames_done++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [7:0] d, input bit accepted);
        exp_t e;
        @(negedge clk);
        if (accepted) begin
            e.data     = d;
            e.par_en   = parity_en;
            e.par_odd  = parity_odd;
            e.two_stop = two_stop;
            e.wr_tick  = tick_num;
            exp_q.push_back(e);
        end
        bus.write_data  = 1'b1;
        bus.bus_data_in = d;
        @(negedge clk);
        bus.write_data  = 1'b0;
    endtask

    task automatic clear_status();
        @(negedge clk);
        bus.clr_status = 1'b1;
        @(negedge clk);
        bus.clr_status = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int max_clks, input string what);
        int n = 0;
        while (frames_done < target && n < max_clks) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (frames_done < target) begin
            n_fail++;
            $display("FAIL %s: frames completed %0d, required %0d", what, frames_done, target);
        end
        repeat (24) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.write_data  = 1'b0;
        bus.bus_data_in = '0;
        bus.clr_status  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (serial_data_out !== 1'b1 || tx_busy !== 1'b0 || bus.status_register !== 8'h02) begin
            n_fail++;
            $display("FAIL reset_hold: line=%b busy=%b status=%h, required 1 0 02",
                     serial_data_out, tx_busy, bus.status_register);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (serial_data_out !== 1'b1 || tx_busy !== 1'b0 || bus.status_register !== 8'h02) begin
            n_fail++;
            $display("FAIL reset_release: line=%b busy=%b status=%h, required 1 0 02",
                     serial_data_out, tx_busy, bus.status_register);
        end
    endtask

    task automatic test_8n1();
        int base = frames_done;
        parity_en = 1'b0;
        two_stop  = 1'b0;
        tick_en   = 1'b1;
        clear_status();
        write_word(8'hA5, 1'b1);
        n_checks++;
        if (bus.status_register[ST_EMPTY] !== 1'b0 || bus.status_register[ST_DONE] !== 1'b0) begin
            n_fail++;
            $display("FAIL 8n1_queued: empty=%b done=%b, required 0 0",
                     bus.status_register[ST_EMPTY], bus.status_register[ST_DONE]);
        end
        wait_frames(base + 1, 2000, "8n1_frame");
        n_checks++;
        if (bus.status_register !== 8'h0A || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL 8n1_after: status=%h busy=%b, required 0a 0",
                     bus.status_register, tx_busy);
        end
        clear_status();
        n_checks++;
        if (bus.status_register[ST_DONE] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear: done=%b, required 0", bus.status_register[ST_DONE]);
        end
    endtask

    task automatic test_parity();
        int base = frames_done;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        write_word(8'h03, 1'b1);
        wait_frames(base + 1, 2000, "parity_odd_frame");
        parity_odd = 1'b0;
        write_word(8'h03, 1'b1);
        wait_frames(base + 2, 2000, "parity_even_frame");
        parity_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base = frames_done;
        int s0;
        int s1;
        two_stop = 1'b1;
        start_q.delete();
        write_word(8'hFF, 1'b1);
        write_word(8'h00, 1'b1);
        wait_frames(base + 2, 4000, "two_stop_frames");
        two_stop = 1'b0;
        n_checks++;
        if (start_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_starts: frames seen %0d, required 2", start_q.size());
        end else begin
            s0 = start_q[0];
            s1 = start_q[1];
            if (s1 - s0 != 176) begin
                n_fail++;
                $display("FAIL b2b_gap: frame spacing %0d ticks, required 176", s1 - s0);
            end
        end
    endtask

    task automatic test_overflow();
        int base = frames_done;
        tick_en = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            write_word(8'(8'h10 + 8'(i * 17)), 1'b1);
        end
        n_checks++;
        if (bus.status_register[ST_FULL] !== 1'b1 || bus.status_register[ST_OVF] !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full: full=%b ovf=%b, required 1 0",
                     bus.status_register[ST_FULL], bus.status_register[ST_OVF]);
        end
        write_word(8'hEE, 1'b0);
        n_checks++;
        if (bus.status_register[ST_OVF] !== 1'b1 || bus.status_register[ST_FULL] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: ovf=%b full=%b, required 1 1",
                     bus.status_register[ST_OVF], bus.status_register[ST_FULL]);
        end
        clear_status();
        n_checks++;
        if (bus.status_register[ST_OVF] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: ovf=%b, required 0", bus.status_register[ST_OVF]);
        end
        // Simultaneous write-while-full and clear: the set must win.
        @(negedge clk);
        bus.write_data  = 1'b1;
        bus.bus_data_in = 8'hDD;
        bus.clr_status  = 1'b1;
        @(negedge clk);
        bus.write_data  = 1'b0;
        bus.clr_status  = 1'b0;
        n_checks++;
        if (bus.status_register[ST_OVF] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set_wins: ovf=%b, required 1", bus.status_register[ST_OVF]);
        end
        clear_status();
        tick_en = 1'b1;
        wait_frames(base + 8, 9000, "fifo_drain");
        n_checks++;
        if (bus.status_register[ST_EMPTY] !== 1'b1 || bus.status_register[ST_FULL] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b full=%b, required 1 0",
                     bus.status_register[ST_EMPTY], bus.status_register[ST_FULL]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int n = 0;
        write_word(8'h5A, 1'b1);
        write_word(8'h11, 1'b1);
        while (!(mon_active && bit_idx == 4 && sub >= 6) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!(mon_active && bit_idx == 4)) begin
            n_fail++;
            $display("FAIL reach_data_bit3: monitor bit %0d, required 4", bit_idx);
        end
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (serial_data_out !== 1'b1 || tx_busy !== 1'b0 || bus.status_register !== 8'h02) begin
            n_fail++;
            $display("FAIL reset_mid_frame: line=%b busy=%b status=%h, required 1 0 02",
                     serial_data_out, tx_busy, bus.status_register);
        end
        repeat (8) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        base = frames_done;
        write_word(8'h3C, 1'b1);
        wait_frames(base + 1, 2000, "after_reset_frame");
    endtask

    task automatic test_toggle_parity();
        int base = frames_done;
        int n = 0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        write_word(8'h81, 1'b1);
        while (!(mon_active && bit_idx >= 2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        parity_en = 1'b1;
        write_word(8'h7E, 1'b1);
        wait_frames(base + 2, 4000, "toggle_frames");
        parity_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_toggle_parity();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d words never transmitted, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
